bin16_to_lcd_ascii: RTL and testbench

- Sequential double-dabble converter between the 16-bit Fibonacci generator output and the LCD controller.
- Watches the binary value, re-converts whenever it changes, and presents 5 packed BCD digits plus 5 ASCII characters ready for the LCD character writer.
- Handshake is a one-cycle done pulse plus a busy level, so the LCD stage refreshes only on new data.

---
 rtl/lcd_pkg.sv | 16 +
 rtl/bcd_add3.sv | 9 +
 rtl/bin16_to_lcd_ascii.sv | 151 +++++++++++++++
 tb/tb_bin16_to_lcd_ascii.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the binary-to-LCD path: character codes, digit count
// and the converter's state encoding.
package lcd_pkg;

    localparam int unsigned LCD_DIGITS = 5;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_FORMAT = 2'd2;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    assign dout_c = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin16_to_lcd_ascii.sv
// Sequential double-dabble converter: re-converts bin_in whenever it changes
// and presents packed BCD plus ASCII characters for the LCD writer.
module bin16_to_lcd_ascii
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DIGITS      = LCD_DIGITS,
    parameter bit          BLANK_ZEROS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [8*DIGITS-1:0]   ascii_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CHR_W = 8 * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // Idle display: blanks with a units '0', or all zeros without blanking.
    function automatic logic [CHR_W-1:0] reset_ascii();
        logic [CHR_W-1:0] r;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[8*i +: 8] = (BLANK_ZEROS && (i != 0)) ? ASCII_SPACE : ASCII_ZERO;
        end
        return r;
    endfunction

    localparam logic [CHR_W-1:0] ASCII_RST = reset_ascii();

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shift_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj_c;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   last_q;
    logic               pending_q;
    logic               trigger_c;
    logic               load_c;
    logic               step_c;
    logic               fmt_c;
    logic               req_c;
    logic [CHR_W-1:0]   ascii_fmt_c;
    logic [3:0]         dig_c;
    logic               lead_c;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
        bcd_add3 u_add3 (
            .din    (bcd_q[4*g +: 4]),
            .dout_c (bcd_adj_c[4*g +: 4])
        );
    end

    assign trigger_c = pending_q | start | (bin_in != last_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (trigger_c) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FORMAT;
            ST_FORMAT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath controls; a change or start while busy queues one rerun.
    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        fmt_c  = 1'b0;
        req_c  = 1'b0;
        case (state_q)
            ST_IDLE:   load_c = trigger_c;
            ST_SHIFT:  step_c = 1'b1;
            ST_FORMAT: fmt_c  = 1'b1;
            default:   ;
        endcase
        if (state_q != ST_IDLE) begin
            req_c = start | (bin_in != last_q);
        end
    end

    // Leading zeros blank until the first nonzero digit; the units digit always shows.
    always_comb begin
        ascii_fmt_c = '0;
        lead_c      = 1'b1;
        dig_c       = 4'd0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            dig_c = bcd_q[4*i +: 4];
            if (BLANK_ZEROS && lead_c && (dig_c == 4'd0) && (i != 0)) begin
                ascii_fmt_c[8*i +: 8] = ASCII_SPACE;
            end else begin
                ascii_fmt_c[8*i +: 8] = ASCII_ZERO + {4'h0, dig_c};
            end
            if (dig_c != 4'd0) begin
                lead_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            pending_q <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            ascii_out <= ASCII_RST;
        end else begin
            done <= fmt_c;
            if (load_c) begin
                shift_q   <= bin_in;
                last_q    <= bin_in;
                bcd_q     <= '0;
                cnt_q     <= '0;
                pending_q <= 1'b0;
                busy      <= 1'b1;
            end
            if (step_c) begin
                bcd_q   <= {bcd_adj_c[BCD_W-2:0], shift_q[WIDTH-1]};
                shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (fmt_c) begin
                bcd_out   <= bcd_q;
                ascii_out <= ascii_fmt_c;
                busy      <= 1'b0;
            end
            if (req_c) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin16_to_lcd_ascii.sv
// Self-checking bench: a transaction-level model predicts busy/done/bcd/ascii
// for a blanking and a non-blanking instance; directed cases pin the model.
module tb_bin16_to_lcd_ascii;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int          LAT    = WIDTH + 1;

    logic        clk;
    logic        reset;
    logic [15:0] bin_in;
    logic        start;
    logic        busy_b, done_b, busy_z, done_z;
    logic [19:0] bcd_b, bcd_z;
    logic [39:0] asc_b, asc_z;

    int vectors;
    int errors;
    bit chk_en;

    bin16_to_lcd_ascii #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_ZEROS(1'b1)) u_blank (
        .clk(clk), .reset(reset), .bin_in(bin_in), .start(start),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ascii_out(asc_b)
    );

    bin16_to_lcd_ascii #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_ZEROS(1'b0)) u_zero (
        .clk(clk), .reset(reset), .bin_in(bin_in), .start(start),
        .busy(busy_z), .done(done_z), .bcd_out(bcd_z), .ascii_out(asc_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [39:0] to_ascii(input int v, input bit blank);
        logic [39:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            if (blank && (i != 0) && (v < p)) r[8*i +: 8] = 8'h20;
            else                              r[8*i +: 8] = 8'h30 + 8'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a conversion takes LAT edges after the loading edge.
    logic        m_busy, m_done, m_pend;
    logic [19:0] m_bcd;
    logic [39:0] m_asc1, m_asc0;
    logic [15:0] m_last, m_val;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_bcd  <= '0;
            m_asc1 <= to_ascii(0, 1'b1);
            m_asc0 <= to_ascii(0, 1'b0);
            m_last <= '0;
            m_val  <= '0;
            m_pend <= 1'b1;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (start || (bin_in != m_last)) m_pend <= 1'b1;
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_bcd  <= to_bcd(int'(m_val));
                    m_asc1 <= to_ascii(int'(m_val), 1'b1);
                    m_asc0 <= to_ascii(int'(m_val), 1'b0);
                end
            end else if (m_pend || start || (bin_in != m_last)) begin
                m_val  <= bin_in;
                m_last <= bin_in;
                m_pend <= 1'b0;
                m_busy <= 1'b1;
                m_left <= LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_b", 64'(busy_b), 64'(m_busy));
            chk("done_b", 64'(done_b), 64'(m_done));
            chk("bcd_b",  64'(bcd_b),  64'(m_bcd));
            chk("asc_b",  64'(asc_b),  64'(m_asc1));
            chk("busy_z", 64'(busy_z), 64'(m_busy));
            chk("done_z", 64'(done_z), 64'(m_done));
            chk("bcd_z",  64'(bcd_z),  64'(m_bcd));
            chk("asc_z",  64'(asc_z),  64'(m_asc0));
        end
    end

    // Returns the number of rising edges until done is seen (first edge counted as 1).
    task automatic wait_done(input string tag, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = done_b;
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: got no done after %0d edges, expected done", tag, n);
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done_b) cnt++;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic pin(input string tag, input logic [19:0] eb, input logic [39:0] e1,
                       input logic [39:0] e0);
        chk({tag, "_bcd"},  64'(bcd_b), 64'(eb));
        chk({tag, "_ascb"}, 64'(asc_b), 64'(e1));
        chk({tag, "_ascz"}, 64'(asc_z), 64'(e0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, expected end of test", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic [39:0] s1, s0;
        vectors = 0;
        errors  = 0;
        chk_en  = 1'b0;
        reset   = 1'b0;
        bin_in  = '0;
        start   = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        s1 = "    0"; s0 = "00000";
        chk("rst_busy", 64'(busy_b), 64'(0));
        chk("rst_done", 64'(done_b), 64'(0));
        pin("rst", 20'h00000, s1, s0);

        // Auto conversion after release: done 17 edges after the sampling edge.
        step(1);
        reset = 1'b1;
        wait_done("post_reset", n);
        chk("lat_reset", 64'(n - 1), 64'(17));
        pin("zero", 20'h00000, s1, s0);
        count_done(10, cnt);
        chk("idle_no_done", 64'(cnt), 64'(0));

        step(1);
        bin_in = 16'd1597;
        wait_done("c1597", n);
        chk("lat_1597", 64'(n - 1), 64'(17));
        s1 = " 1597"; s0 = "01597";
        pin("c1597", 20'h01597, s1, s0);

        step(1);
        bin_in = 16'd65535;
        wait_done("c65535", n);
        s1 = "65535"; s0 = "65535";
        pin("c65535", 20'h65535, s1, s0);

        step(1);
        bin_in = 16'd1000;
        wait_done("c1000", n);
        s1 = " 1000"; s0 = "01000";
        pin("c1000", 20'h01000, s1, s0);

        // Value changes mid-conversion: first result keeps the captured value.
        step(1);
        bin_in = 16'd144;
        step(6);
        bin_in = 16'd233;
        wait_done("c144", n);
        s1 = "  144"; s0 = "00144";
        pin("c144", 20'h00144, s1, s0);
        wait_done("c233", n);
        chk("lat_233", 64'(n), 64'(18));
        s1 = "  233"; s0 = "00233";
        pin("c233", 20'h00233, s1, s0);

        step(1);
        bin_in = 16'd89;
        wait_done("c89", n);
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done("start89", n);
        s1 = "   89"; s0 = "00089";
        pin("start89", 20'h00089, s1, s0);

        // Start held while busy queues exactly one extra conversion.
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(3);
        start = 1'b0;
        count_done(60, cnt);
        chk("start_held_dones", 64'(cnt), 64'(2));

        // Reset during SHIFT abandons the conversion.
        step(1);
        bin_in = 16'd4181;
        step(9);
        #2;
        reset = 1'b0;
        #1;
        s1 = "    0"; s0 = "00000";
        chk("mid_rst_busy", 64'(busy_b), 64'(0));
        chk("mid_rst_done", 64'(done_b), 64'(0));
        pin("mid_rst", 20'h00000, s1, s0);
        step(2);
        reset = 1'b1;
        wait_done("c4181", n);
        chk("lat_4181", 64'(n - 1), 64'(17));
        s1 = " 4181"; s0 = "04181";
        pin("c4181", 20'h04181, s1, s0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step(1);
            if ($urandom_range(0, 9) == 0)
                bin_in = 16'($urandom) >> $urandom_range(0, 15);
            start = ($urandom_range(0, 15) == 0);
        end
        start = 1'b0;
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
